// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) digit-serial multiplier: FSM state
// encoding, the ceil-div helper used to size the digit count, and the
// default AES field polynomial x^8 + x^4 + x^3 + x + 1.
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [8:0] AES_POLY = 9'h11B;

  // Number of D-bit digits needed to cover an n-bit operand.
  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit step of the MSB-first multiplier:
//   z_next_c_o = (z_i * x^D + a_i * bd_i) mod POLY
// Purely combinational. The digit is folded in Horner style, one bit at a
// time from its MSB, so every intermediate value stays M bits wide and only
// needs a single conditional XOR with POLY per bit.
// Ports:
//   z_i        - current accumulator (M bits)
//   a_i        - multiplicand (M bits)
//   bd_i       - current multiplier digit (D bits)
//   z_next_c_o - reduced next accumulator value (M bits, combinational)
module gf2m_digit_step #(
  parameter int unsigned M    = 8,
  parameter int unsigned D    = 1,
  parameter logic [M:0]  POLY = 9'h11B
) (
  input  logic [M-1:0] z_i,
  input  logic [M-1:0] a_i,
  input  logic [D-1:0] bd_i,
  output logic [M-1:0] z_next_c_o
);

  logic [M-1:0] acc;

  // Multiply by x with reduction, then conditionally add a, once per digit bit.
  always_comb begin
    acc = z_i;
    for (int j = int'(D) - 1; j >= 0; j--) begin
      if (acc[M-1]) begin
        acc = M'(acc << 1) ^ POLY[M-1:0];
      end else begin
        acc = M'(acc << 1);
      end
      if (bd_i[j]) begin
        acc = acc ^ a_i;
      end
    end
    z_next_c_o = acc;
  end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier, y = a*b mod POLY.
// Processes D multiplier bits per cycle, MSB digit first, K = ceil(M/D)
// cycles per product. Valid/ready handshake on both sides.
// Optional feature macro: GF_MULT_ACC_EN adds acc_mode/c inputs; with
// acc_mode=1 the result is a*b XOR c at the same latency.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake (in_ready only in IDLE)
//   a, b                - multiplicand, multiplier (M bits)
//   out_valid, out_ready- result handshake (out_valid only in DONE)
//   y                   - last completed product (M bits)
//   acc_mode, c         - accumulate enable and addend (GF_MULT_ACC_EN only)
module gf2m_digit_serial_mult
  import gf2m_pkg::*;
#(
  parameter int unsigned M    = 8,
  parameter int unsigned D    = 1,
  parameter logic [M:0]  POLY = (M+1)'(AES_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
`ifdef GF_MULT_ACC_EN
  input  logic         acc_mode,
  input  logic [M-1:0] c,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] y
);

  localparam int unsigned K  = ceil_div(M, D);
  localparam int unsigned KD = K * D;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  state_e        state_q, state_d;
  logic [M-1:0]  a_q, a_d;
  logic [KD-1:0] b_q, b_d;
  logic [M-1:0]  z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  y_q, y_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [M-1:0]  z_next;
  logic [M-1:0]  addend;
`ifdef GF_MULT_ACC_EN
  logic [M-1:0]  c_q, c_d;
`endif

  // Current digit is always the top D bits of the shifting multiplier register.
  gf2m_digit_step #(
    .M    (M),
    .D    (D),
    .POLY (POLY)
  ) u_step (
    .z_i        (z_q),
    .a_i        (a_q),
    .bd_i       (b_q[KD-1 -: D]),
    .z_next_c_o (z_next)
  );

  // The addend is XORed in at completion rather than preloaded into Z, since
  // a preloaded value would be scaled by x^(K*D) by the Horner iterations.
`ifdef GF_MULT_ACC_EN
  assign addend = c_q;
`else
  assign addend = '0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef GF_MULT_ACC_EN
      c_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef GF_MULT_ACC_EN
      c_q         <= c_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
`ifdef GF_MULT_ACC_EN
    c_d     = c_q;
`endif

    case (state_q)
      IDLE: begin
        // in_ready_q gates the accept so nothing is taken on the first edge after reset.
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = KD'(b);
          z_d     = '0;
          cnt_d   = CW'(K - 1);
          state_d = CALC;
`ifdef GF_MULT_ACC_EN
          c_d     = acc_mode ? c : '0;
`endif
        end
      end
      CALC: begin
        z_d = z_next;
        b_d = KD'(b_q << D);
        if (cnt_q == '0) begin
          y_d     = z_next ^ addend;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule
